// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between instruction fetch, the fetch queue and decode.
// Ports: flush; in_valid/in_ready/in_inst/in_pc_plus_4 (fetch side);
//        out_valid/out_ready/out_inst/out_pc_plus_4 (decode side); count (occupancy).
// slave modport is the queue itself; master modport is whoever drives fetch/decode.
interface fetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_inst;
  logic [ADDR_W-1:0] in_pc_plus_4;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc_plus_4;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  flush, in_valid, in_inst, in_pc_plus_4, out_ready,
    output in_ready, out_valid, out_inst, out_pc_plus_4, count
  );

  modport master (
    output flush, in_valid, in_inst, in_pc_plus_4, out_ready,
    input  in_ready, out_valid, out_inst, out_pc_plus_4, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: FWFT circular buffer of {instruction, PC+4} between fetch and decode.
// Latency: entry pushed at edge N is on out_* after edge N (no in->out bypass).
// Backpressure: in_ready = !full from registered state only; pop while full frees no slot that cycle.
// Ports: clk, rst (sync, active-high), bus (fetch_queue_if.slave: flush, in_*, out_*, count).
module fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] NOP_INST = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_e;

  occ_e              state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  // Handshake readiness comes straight from the occupancy state register,
  // so in_ready never combinationally depends on out_ready.
  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.count     = count_q;

  // Head is read combinationally and masked while empty.
  assign bus.out_inst      = bus.out_valid ? inst_mem[rd_ptr_q] : NOP_INST;
  assign bus.out_pc_plus_4 = bus.out_valid ? pc_mem[rd_ptr_q]   : '0;

  always_comb begin
    push     = bus.in_valid  & bus.in_ready  & ~bus.flush;
    pop      = bus.out_valid & bus.out_ready & ~bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) count_d = count_q + CNT_W'(1);
      if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Occupancy state tracks the next count so flags are registered.
    if (count_d == '0)                 state_d = ST_EMPTY;
    else if (count_d == CNT_W'(DEPTH)) state_d = ST_FULL;
    else                               state_d = ST_PARTIAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_mem[wr_ptr_q] <= bus.in_inst;
      pc_mem[wr_ptr_q]   <= bus.in_pc_plus_4;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table, hand sequences and randomized traffic
// checked against a queue-based reference model of the fetch queue.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_INST(32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of buffered {inst, pc} entries, head at index 0.
  logic [31:0] m_inst[$];
  logic [31:0] m_pc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [31:0] inst, input logic [31:0] pc);
    rst              = r;
    bus.flush        = f;
    bus.in_valid     = iv;
    bus.out_ready    = ordy;
    bus.in_inst      = inst;
    bus.in_pc_plus_4 = pc;
  endtask

  // Model step from the specification's rules, evaluated on the pre-edge state.
  task automatic model_step();
    bit do_push, do_pop;
    if (rst || bus.flush) begin
      m_inst.delete();
      m_pc.delete();
    end else begin
      do_push = bus.in_valid && (m_inst.size() < DEPTH);
      do_pop  = bus.out_ready && (m_inst.size() > 0);
      if (do_pop) begin
        void'(m_inst.pop_front());
        void'(m_pc.pop_front());
      end
      if (do_push) begin
        m_inst.push_back(bus.in_inst);
        m_pc.push_back(bus.in_pc_plus_4);
      end
    end
  endtask

  // One clock: inputs already driven at negedge; update model at posedge,
  // return at the following negedge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    int n;
    n = m_inst.size();
    chk({tag, "_count"},     32'(bus.count),     32'(n));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(n > 0));
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(n < DEPTH));
    chk({tag, "_out_inst"},  bus.out_inst,       (n > 0) ? m_inst[0] : 32'h0);
    chk({tag, "_out_pc"},    bus.out_pc_plus_4,  (n > 0) ? m_pc[0]   : 32'h0);
  endtask

  typedef struct {
    logic        r, f, iv, ordy;
    logic [31:0] inst, pc;
    int          e_count;
    logic        e_ov, e_ir;
    logic [31:0] e_inst, e_pc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] popped[$];
    logic [31:0] exp_pop[$];
    int k;

    drive(1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);

    // ---- vector table: reset, fill to full, reject fifth push, pop from full
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0, 32'h0,        32'd0,  0, 1'b0,1'b1, 32'h0,        32'd0};
    vecs[1] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,        32'd0,  0, 1'b0,1'b1, 32'h0,        32'd0};
    vecs[2] = '{1'b0,1'b0,1'b1,1'b0, 32'h11111111, 32'd4,  1, 1'b1,1'b1, 32'h11111111, 32'd4};
    vecs[3] = '{1'b0,1'b0,1'b1,1'b0, 32'h22222222, 32'd8,  2, 1'b1,1'b1, 32'h11111111, 32'd4};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b0, 32'h33333333, 32'd12, 3, 1'b1,1'b1, 32'h11111111, 32'd4};
    vecs[5] = '{1'b0,1'b0,1'b1,1'b0, 32'h44444444, 32'd16, 4, 1'b1,1'b0, 32'h11111111, 32'd4};
    vecs[6] = '{1'b0,1'b0,1'b1,1'b0, 32'h55555555, 32'd20, 4, 1'b1,1'b0, 32'h11111111, 32'd4};
    // full: pop with in_valid high does not admit 0x55555555 this cycle
    vecs[7] = '{1'b0,1'b0,1'b1,1'b1, 32'h55555555, 32'd20, 3, 1'b1,1'b1, 32'h22222222, 32'd8};
    vecs[8] = '{1'b0,1'b1,1'b0,1'b0, 32'h0,        32'd0,  0, 1'b0,1'b1, 32'h0,        32'd0};

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].ordy, vecs[i].inst, vecs[i].pc);
      tick();
      chk($sformatf("vec%0d_count", i),     32'(bus.count),     32'(vecs[i].e_count));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_inst", i),  bus.out_inst,       vecs[i].e_inst);
      chk($sformatf("vec%0d_out_pc", i),    bus.out_pc_plus_4,  vecs[i].e_pc);
    end

    // ---- from full, continuous push+pop for 10 cycles with wrap-around
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 32'h11111111 * (i + 1), 32'(4 * (i + 1)));
      tick();
    end
    chk("full_count", 32'(bus.count), 32'd4);
    exp_pop = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 6; i++) exp_pop.push_back(32'hC000_0000 + 32'(i));
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 1, 1, 32'hC000_0000 + 32'(k), 32'h100 + 32'(4 * k));
      if (bus.out_valid) popped.push_back(bus.out_inst);
      if (bus.in_ready) k++;
      tick();
      chk($sformatf("stream%0d_count", c), 32'(bus.count), 32'd3);
    end
    chk("stream_pop_total", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("stream_pop%0d", i), (i < popped.size()) ? popped[i] : 32'hxxxx_xxxx, exp_pop[i]);

    // ---- push into empty with out_ready held: 0 -> 1 -> 0
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 32'hAAAA0001, 32'h44); tick();
    chk("empty_push_count", 32'(bus.count), 32'd1);
    chk("empty_push_valid", 32'(bus.out_valid), 32'd1);
    chk("empty_push_inst", bus.out_inst, 32'hAAAA0001);
    drive(0, 0, 0, 1, 0, 0); tick();
    chk("last_pop_count", 32'(bus.count), 32'd0);
    chk("last_pop_valid", 32'(bus.out_valid), 32'd0);
    chk("last_pop_pc", bus.out_pc_plus_4, 32'h0);

    // ---- flush at count=3 with concurrent push and pop, then held flush
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 32'hF000_0000 + 32'(i), 32'(8 * i)); tick();
    end
    chk("pre_flush_count", 32'(bus.count), 32'd3);
    drive(0, 1, 1, 1, 32'hDEAD_DEAD, 32'h99); tick();
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_inst", bus.out_inst, 32'h0);
    tick();
    chk("flush2_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush2_count", 32'(bus.count), 32'd0);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("post_flush_valid", 32'(bus.out_valid), 32'd0);

    // ---- reset mid-operation at count=2, then first push emerges first
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 32'hE000_0000 + 32'(i), 32'(4 * i)); tick();
    end
    drive(1, 0, 1, 1, 32'h1234_5678, 32'h20); tick();
    chk("rst_mid_count", 32'(bus.count), 32'd0);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mid_inst", bus.out_inst, 32'h0);
    drive(0, 0, 1, 0, 32'hBEEF0000, 32'h40); tick();
    chk("after_rst_inst", bus.out_inst, 32'hBEEF0000);
    chk("after_rst_pc", bus.out_pc_plus_4, 32'h40);

    // ---- randomized traffic against the reference model
    drive(1, 0, 0, 0, 0, 0); tick();
    chk_model("rand_rst");
    for (int c = 0; c < 800; c++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 5),
            $urandom, $urandom);
      tick();
      chk_model($sformatf("rand%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised, first-word-fall-through instruction queue placed between instruction fetch and decode. Each entry holds an instruction and its PC+4. A valid/ready handshake on both sides lets fetch run ahead while decode is stalled, up to DEPTH entries. A single-cycle flush discards all buffered entries on branch/jump redirect.

## Interface
- DATA_W, 32: instruction width.
- ADDR_W, 32: PC+4 width.
- DEPTH, 4: number of entries. Power of two, ≥2.
- NOP_INST, 32'h0000_0000: value driven on out_inst whenever out_valid=0.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all entries and the current push.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept; equals !full.
- in_inst  in  DATA_W  instruction from fetch.
- in_pc_plus_4  in  ADDR_W  PC+4 from fetch.
- out_valid  out  1  head entry present; equals !empty.
- out_ready  in  1  decode consumes the head.
- out_inst  out  DATA_W  head instruction, or NOP_INST when empty.
- out_pc_plus_4  out  ADDR_W  head PC+4, or 0 when empty.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- push = in_valid & in_ready & !flush.
- pop = out_valid & out_ready & !flush.
- On push: write the entry at wr_ptr, then increment wr_ptr.
- On pop: increment rd_ptr.
- count next value:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Head read is combinational from storage at rd_ptr, so no extra register stage sits on the output.
- in_ready depends only on registered state (count != DEPTH). It never depends on out_ready. When full, a same-cycle pop does not enable a push.
- Flush: wr_ptr=rd_ptr=0 and count=0 next cycle. Any concurrent push and pop are ignored. Storage contents need not be cleared.
- rst behaves like flush and has priority over it.
- Outputs are masked when empty: out_inst=NOP_INST, out_pc_plus_4=0.
- Occupancy states:
  - EMPTY: count=0.
  - PARTIAL: 0<count<DEPTH.
  - FULL: count=DEPTH.
  - Transitions follow the count rule. Any state goes to EMPTY on flush or rst.

## Timing
- Reset values, in the cycle after rst is sampled high: count=0, out_valid=0, in_ready=1, out_inst=NOP_INST, out_pc_plus_4=0.
- Latency: an entry pushed at edge N is visible on out_* after edge N; it can be popped at edge N+1. There is no bypass from in_* to out_*.
- Throughput: one push and one pop per cycle in steady state when 0<count<DEPTH.
- Push into an empty queue with out_ready=1 in the same cycle: only the push happens, and count becomes 1.
- Pop from the last entry with no push: out_valid=0 next cycle and outputs return to their masked values.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- Flush asserted for consecutive cycles: the queue stays EMPTY and in_ready stays 1.
- rst asserted mid-operation: same as flush, and in-flight handshakes are dropped.
- in_valid with in_ready=0: the queue holds no state change for that entry. Fetch must hold its data until accepted.

## Test plan
- Reset then idle, DEPTH=4 → count=0, out_valid=0, in_ready=1, out_inst=0x00000000, out_pc_plus_4=0.
- Push 0x11111111/4, 0x22222222/8, 0x33333333/12, 0x44444444/16 with out_ready=0 → count=4, in_ready=0, out_inst=0x11111111. A fifth push of 0x55555555 is not accepted.
- From full, set out_ready=1 and in_valid=1 continuously for 10 cycles → entries pop in order with no duplicates or drops. Pointers wrap, count oscillates 4→3 and then holds 3, and the first accepted new entry appears after the original four.
- Push 0xAAAA0001 into an empty queue with out_ready=1 held → out_valid rises one cycle after the push and the pop occurs the following cycle. count goes 0→1→0.
- With count=3, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, out_inst=NOP_INST, and the concurrent entry never appears.
- Assert rst while count=2 and push/pop are active → next cycle all reset values hold. A subsequent push of 0xBEEF0000/0x40 emerges as the first output.
